// File: rtl/usb_data_buffer_if.sv
// usb_data_buffer_if: strobe/data bundle between the USB/AHB clients and the byte FIFO
interface usb_data_buffer_if #(parameter int OCC_W = 7);
  logic             store_rx_packet_data;
  logic [7:0]       rx_packet_data;
  logic             get_rx_data;
  logic [7:0]       rx_data;
  logic             store_tx_data;
  logic [7:0]       tx_data;
  logic             get_tx_packet_data;
  logic [7:0]       tx_packet_data;
  logic             flush;
  logic             clear;
  logic [OCC_W-1:0] buffer_occupancy;
  logic             overrun;
  logic             underrun;
  modport master (
    output store_rx_packet_data, rx_packet_data, get_rx_data,
    output store_tx_data, tx_data, get_tx_packet_data, flush, clear,
    input  rx_data, tx_packet_data, buffer_occupancy, overrun, underrun
  );
  modport slave (
    input  store_rx_packet_data, rx_packet_data, get_rx_data,
    input  store_tx_data, tx_data, get_tx_packet_data, flush, clear,
    output rx_data, tx_packet_data, buffer_occupancy, overrun, underrun
  );
endinterface

// File: rtl/usb_data_buffer.sv
// usb_data_buffer: single-clock byte FIFO shared by the USB RX/TX datapath and the AHB slave
module usb_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int OCC_W  = 7
) (
  input logic               clk,
  input logic               n_rst,
  usb_data_buffer_if.slave  bus
);
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              overrun_q, overrun_d, underrun_q, underrun_d;
  logic              fl, wr_en, rd_en, wr_acc, rd_acc;
  logic [7:0]        wr_data;
  // Acceptance is judged on the count at the start of the cycle; a full buffer may take a write only alongside a read
  always_comb begin
    fl         = bus.flush | bus.clear;
    wr_en      = bus.store_rx_packet_data | bus.store_tx_data;
    rd_en      = bus.get_rx_data | bus.get_tx_packet_data;
    wr_data    = bus.store_rx_packet_data ? bus.rx_packet_data : bus.tx_data;
    rd_acc     = !fl && rd_en && count_q != '0;
    wr_acc     = !fl && wr_en && (count_q != OCC_W'(DEPTH) || rd_acc);
    wptr_d     = fl ? '0 : wptr_q + ADDR_W'(wr_acc);
    rptr_d     = fl ? '0 : rptr_q + ADDR_W'(rd_acc);
    count_d    = fl ? '0 : count_q + OCC_W'(wr_acc) - OCC_W'(rd_acc);
    overrun_d  = !fl && ((wr_en && !wr_acc) || (bus.store_rx_packet_data && bus.store_tx_data));
    underrun_d = !fl && rd_en && count_q == '0;
  end
  // Pointer, occupancy and error-pulse state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end
  // Storage array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wr_data;
  end
  assign bus.rx_data          = count_q != '0 ? mem_q[rptr_q] : 8'h00;
  assign bus.tx_packet_data   = bus.rx_data;
  assign bus.buffer_occupancy = count_q;
  assign bus.overrun          = overrun_q;
  assign bus.underrun         = underrun_q;
endmodule

// File: tb/tb_usb_data_buffer.sv
// tb_usb_data_buffer: vector table plus scoreboard-driven corner sequences for the byte FIFO
module tb_usb_data_buffer;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  usb_data_buffer_if bus();
  usb_data_buffer dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       srx;
    logic [7:0] rxd;
    logic       grx;
    logic       stx;
    logic [7:0] txd;
    logic       gtx;
    logic       fl;
    logic       cl;
    logic [6:0] occ;
    logic [7:0] head;
    logic       ov;
    logic       un;
  } vec_t;
  vec_t vt[18];
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_out(input string nm, input logic [6:0] occ, input logic [7:0] head,
                         input logic ov, input logic un);
    chk({nm, ".occ"}, {1'b0, bus.buffer_occupancy}, {1'b0, occ});
    chk({nm, ".rx_data"}, bus.rx_data, head);
    chk({nm, ".tx_packet_data"}, bus.tx_packet_data, head);
    chk({nm, ".overrun"}, {7'd0, bus.overrun}, {7'd0, ov});
    chk({nm, ".underrun"}, {7'd0, bus.underrun}, {7'd0, un});
  endtask
  task automatic set_in(input logic srx, input logic [7:0] rxd, input logic grx, input logic stx,
                        input logic [7:0] txd, input logic gtx, input logic fl, input logic cl);
    bus.store_rx_packet_data = srx;
    bus.rx_packet_data       = rxd;
    bus.get_rx_data          = grx;
    bus.store_tx_data        = stx;
    bus.tx_data              = txd;
    bus.get_tx_packet_data   = gtx;
    bus.flush                = fl;
    bus.clear                = cl;
  endtask
  task automatic drive(input logic srx, input logic [7:0] rxd, input logic grx, input logic stx,
                       input logic [7:0] txd, input logic gtx, input logic fl, input logic cl);
    @(negedge clk);
    set_in(srx, rxd, grx, stx, txd, gtx, fl, cl);
    @(posedge clk);
    #1;
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic wr(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    sb.push_back(b);
  endtask
  task automatic rd();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    vt[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd1, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd2, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd3, 8'h00, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd4, 8'h00, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd3, 8'h01, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd2, 8'h02, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd1, 8'h03, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd1, 8'hAA, 1'b0, 1'b1};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 7'd1, 8'h11, 1'b1, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 7'd1, 8'h5A, 1'b0, 1'b0};
    vt[14] = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 7'd0, 8'h00, 1'b0, 1'b0};
    vt[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 7'd1, 8'h77, 1'b0, 1'b0};
    vt[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0};
    set_in(1'b1, 8'hFF, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_out("reset", 7'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk_out("post_reset", 7'd0, 8'h00, 1'b0, 1'b0);
    end
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].srx, vt[i].rxd, vt[i].grx, vt[i].stx, vt[i].txd, vt[i].gtx, vt[i].fl, vt[i].cl);
      chk_out($sformatf("vec%0d", i), vt[i].occ, vt[i].head, vt[i].ov, vt[i].un);
    end
    sb.delete();
    for (int i = 0; i < 64; i++) wr(8'(200 - 2 * i));
    chk_out("full", 7'd64, 8'd200, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_out("full_overrun", 7'd64, 8'd200, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_out("overrun_clears", 7'd64, 8'd200, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_b = sb.pop_front();
      chk("read10_head", bus.rx_data, exp_b);
      rd();
    end
    for (int i = 0; i < 10; i++) wr(8'(30 + i));
    chk_out("wrapped_full", 7'd64, 8'd180, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    sb.push_back(8'hEE);
    chk_out("full_wr_rd", 7'd64, sb[0], 1'b0, 1'b0);
    for (int i = 0; i < 64 && sb.size() > 0; i++) begin
      exp_b = sb.pop_front();
      chk("drain_head", bus.tx_packet_data, exp_b);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk_out("drained", 7'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) wr(8'(i + 1));
    chk_out("pre_flush", 7'd5, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    sb.delete();
    chk_out("flush", 7'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) wr(8'(i + 8'h10));
    chk_out("pre_clear", 7'd5, 8'h10, 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    sb.delete();
    chk_out("clear", 7'd0, 8'h00, 1'b0, 1'b0);
    wr(8'h3C);
    chk_out("after_clear_wr", 7'd1, 8'h3C, 1'b0, 1'b0);
    rd();
    chk_out("after_clear_rd", 7'd0, 8'h00, 1'b0, 1'b0);
    sb.delete();
    for (int i = 0; i < 37; i++) wr(8'(i + 8'h40));
    chk_out("pre_async", 7'd37, 8'h40, 1'b0, 1'b0);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1 chk_out("async_rst", 7'd0, 8'h00, 1'b0, 1'b0);
    #2 n_rst = 1'b1;
    sb.delete();
    wr(8'h5E);
    chk_out("post_async_wr", 7'd1, 8'h5E, 1'b0, 1'b0);
    rd();
    chk_out("post_async_rd", 7'd0, 8'h00, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_data_buffer.md
Name: usb_data_buffer

Overview:
- 64-byte single-clock FIFO between the USB endpoint datapath and the AHB-lite slave.
- RX path: usb_rx writes decoded packet bytes in; the AHB side reads them out.
- TX path: the AHB side writes bytes in; usb_tx reads them out.
- Reports buffer_occupancy back to usb_rx and the AHB slave. Handles flush (from usb_rx at packet start) and clear (from AHB software).

Parameters:
- DEPTH, 64, number of byte entries; must be a power of two.
- ADDR_W, 6, pointer width, equal to log2(DEPTH).
- OCC_W, 7, occupancy width, equal to ADDR_W+1 so the value DEPTH is representable.

Ports:
- clk  in  1  system clock, 108 MHz.
- n_rst  in  1  asynchronous active-low reset.
- store_rx_packet_data  in  1  usb_rx write strobe, one byte per asserted cycle.
- rx_packet_data  in  8  usb_rx write byte.
- get_rx_data  in  1  AHB read strobe for the RX path.
- rx_data  out  8  head byte presented to AHB.
- store_tx_data  in  1  AHB write strobe for the TX path.
- tx_data  in  8  AHB write byte.
- get_tx_packet_data  in  1  usb_tx read strobe.
- tx_packet_data  out  8  head byte presented to usb_tx.
- flush  in  1  synchronous empty request from usb_rx.
- clear  in  1  synchronous empty request from AHB.
- buffer_occupancy  out  7  number of valid bytes, 0..64.
- overrun  out  1  one-cycle pulse when a write is dropped.
- underrun  out  1  one-cycle pulse when a read is dropped.

Behaviour:
- Reset: clk is the only clock; n_rst is asynchronous and active-low. While n_rst=0: wptr=0, rptr=0, count=0, overrun=0, underrun=0, so buffer_occupancy=0, rx_data=0, tx_packet_data=0. Memory contents are not reset.
- Storage: DEPTH x 8 register array, write pointer wptr and read pointer rptr (ADDR_W bits each), count register (OCC_W bits). Pointers wrap 63->0 by natural overflow.
- Write source select: wr_en = store_rx_packet_data | store_tx_data. wr_data = rx_packet_data if store_rx_packet_data=1, else tx_data.
  - If both strobes are asserted, the RX byte wins, the TX byte is dropped and overrun pulses.
- Read select: rd_en = get_rx_data | get_tx_packet_data. If both are asserted, a single byte is popped and no error is raised.
- Acceptance, evaluated on the count value at the start of the cycle:
  - A write is accepted iff count < DEPTH, or count == DEPTH and a read is accepted in the same cycle.
  - A read is accepted iff count > 0.
  - count=0 with write+read: the write is accepted, the read is dropped and underrun pulses, next count=1.
  - count=64 with write+read: both are accepted, count stays 64, wptr and rptr both advance.
  - A dropped write because the buffer is full pulses overrun. A dropped read because the buffer is empty pulses underrun.
- Count update: +1 for an accepted write only, -1 for an accepted read only, unchanged for both or neither. count never exceeds 64 and never goes below 0.
- Flush/clear: flush|clear is synchronous and has highest priority. Next cycle wptr=rptr=count=0. All strobes in that cycle are ignored and produce no overrun/underrun pulse.
- Outputs:
  - buffer_occupancy = count, registered.
  - rx_data = tx_packet_data = mem[rptr] when count>0, else 8'h00. This is a first-word-fall-through head view; there is no combinational path from the strobes.
  - After an accepted write into an empty buffer, the byte appears on rx_data and tx_packet_data one cycle after the strobe.
  - After an accepted read, the next byte appears in the following cycle.
- overrun and underrun are registered one-cycle pulses asserted the cycle after the offending strobe. They are not sticky.
- Reset asserted mid-transfer: everything returns to reset values immediately, asynchronously.

Test Plan:
- Reset: drive all strobes high during reset -> buffer_occupancy=0, rx_data=0, tx_packet_data=0, overrun=0, underrun=0. After release with strobes low, the same values hold for 3 cycles.
- RX fill/drain: store 4 bytes 8'h00..8'h03 via store_rx_packet_data -> occupancy 1,2,3,4 and rx_data=8'h00. Four get_rx_data pulses -> rx_data 8'h01, 8'h02, 8'h03, then 8'h00 with occupancy 0.
- Full/wrap: write bytes 200-2*i for i=0..63 -> occupancy=64. A 65th write -> overrun pulses one cycle, occupancy stays 64. Read 10, write 10 more -> pointers wrap; reading all 64 returns 8'd180 down to the new bytes in exact FIFO order.
- Simultaneous events:
  - Empty with write 8'hAA plus read -> occupancy=1, underrun pulse, head 8'hAA.
  - Full with write plus read -> occupancy stays 64, no pulses.
  - Both write strobes, rx 8'h11 and tx 8'h22 -> 8'h11 stored, overrun pulse.
- Flush vs clear: with occupancy 5, assert flush together with store_rx_packet_data -> next cycle occupancy=0, head 8'h00, no overrun. Repeat with clear -> identical result. The next write lands at entry 0 and reads back correctly.
- Async reset mid-fill: at occupancy 37, pulse n_rst low for half a clock off-edge -> occupancy=0 before the next posedge, and a subsequent write/read behaves as after power-on.
